// File: rtl/bs_pkg.sv
// Shared constants and sizing helpers for the segmented boundary-scan register.
package bs_pkg;

  localparam int DEF_SEG_COUNT = 4;
  localparam int DEF_SEG_WIDTH = 8;

  // Width able to hold the longest path: every SIB plus every segment cell.
  function automatic int chain_len_w(input int seg_count, input int seg_width);
    return $clog2(seg_count * (seg_width + 1) + 1);
  endfunction

endpackage

// File: rtl/bs_cell.sv
// One boundary-scan cell: a shift stage with hold/capture/shift mux and an update stage.
module bs_cell (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic pin,
  input  logic sin,
  output logic shift_q,
  output logic update_q
);

  // Capture wins over shift; an inactive cell holds both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= 1'b0;
    end else if (active) begin
      if (capture_en) begin
        shift_q <= pin;
      end else if (shift_en) begin
        shift_q <= sin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_q <= 1'b0;
    end else if (active && update_en) begin
      update_q <= shift_q;
    end
  end

endmodule

// File: rtl/bs_bsr_sib.sv
// Boundary-scan register split into segments, each gated into the scan path by a SIB.
module bs_bsr_sib
  import bs_pkg::*;
#(
  parameter int SEG_COUNT = DEF_SEG_COUNT,
  parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
  input  logic                                           ClockBR,
  input  logic                                           Rst,
  input  logic                                           CaptureBR,
  input  logic                                           ShiftBR,
  input  logic                                           UpdateBR,
  input  logic                                           ModeControl,
  input  logic                                           SIN,
  input  logic [SEG_COUNT*SEG_WIDTH-1:0]                 DIN,
  output logic [SEG_COUNT*SEG_WIDTH-1:0]                 DOUT,
  output logic                                           SOUT,
  output logic [SEG_COUNT-1:0]                           SegOpen,
  output logic [chain_len_w(SEG_COUNT, SEG_WIDTH)-1:0]   ChainLength
);

  localparam int NBITS = SEG_COUNT * SEG_WIDTH;
  localparam int LEN_W = chain_len_w(SEG_COUNT, SEG_WIDTH);

  logic [SEG_COUNT-1:0] sib_sh;
  logic [SEG_COUNT-1:0] sib_si;
  logic [NBITS-1:0]     seg_sh;
  logic [NBITS-1:0]     seg_up;
  logic [NBITS-1:0]     seg_si;

  genvar k, j;
  generate
    for (k = 0; k < SEG_COUNT; k++) begin : g_seg
      // A SIB is fed by the previous segment's tail when it is open, else by the previous SIB.
      if (k == 0) begin : g_head
        assign sib_si[k] = SIN;
      end else begin : g_link
        assign sib_si[k] = SegOpen[k-1] ? seg_sh[k*SEG_WIDTH-1] : sib_sh[k-1];
      end

      // The SIB recaptures its own update value so a capture never disturbs the path shape.
      bs_cell u_sib (
        .clk        (ClockBR),
        .rst        (Rst),
        .active     (1'b1),
        .capture_en (CaptureBR),
        .shift_en   (ShiftBR),
        .update_en  (UpdateBR),
        .pin        (SegOpen[k]),
        .sin        (sib_si[k]),
        .shift_q    (sib_sh[k]),
        .update_q   (SegOpen[k])
      );

      for (j = 0; j < SEG_WIDTH; j++) begin : g_bit
        if (j == 0) begin : g_first
          assign seg_si[k*SEG_WIDTH] = sib_sh[k];
        end else begin : g_next
          assign seg_si[k*SEG_WIDTH+j] = seg_sh[k*SEG_WIDTH+j-1];
        end

        bs_cell u_cell (
          .clk        (ClockBR),
          .rst        (Rst),
          .active     (SegOpen[k]),
          .capture_en (CaptureBR),
          .shift_en   (ShiftBR),
          .update_en  (UpdateBR),
          .pin        (DIN[k*SEG_WIDTH+j]),
          .sin        (seg_si[k*SEG_WIDTH+j]),
          .shift_q    (seg_sh[k*SEG_WIDTH+j]),
          .update_q   (seg_up[k*SEG_WIDTH+j])
        );
      end
    end
  endgenerate

  assign SOUT = SegOpen[SEG_COUNT-1] ? seg_sh[NBITS-1] : sib_sh[SEG_COUNT-1];
  assign DOUT = ModeControl ? seg_up : DIN;

  always_comb begin
    ChainLength = LEN_W'(SEG_COUNT);
    for (int i = 0; i < SEG_COUNT; i++) begin
      if (SegOpen[i]) begin
        ChainLength = ChainLength + LEN_W'(SEG_WIDTH);
      end
    end
  end

endmodule

// File: tb/tb_bs_bsr_sib.sv
// Bench for bs_bsr_sib: directed scenarios plus random traffic against a path-list model.
module tb_bs_bsr_sib;

  localparam int N  = 2;
  localparam int W  = 4;
  localparam int LW = bs_pkg::chain_len_w(N, W);

  logic            ClockBR = 1'b0;
  logic            Rst;
  logic            CaptureBR;
  logic            ShiftBR;
  logic            UpdateBR;
  logic            ModeControl;
  logic            SIN;
  logic [N*W-1:0]  DIN;
  logic [N*W-1:0]  DOUT;
  logic            SOUT;
  logic [N-1:0]    SegOpen;
  logic [LW-1:0]   ChainLength;

  bs_bsr_sib #(.SEG_COUNT(N), .SEG_WIDTH(W)) dut (
    .ClockBR     (ClockBR),
    .Rst         (Rst),
    .CaptureBR   (CaptureBR),
    .ShiftBR     (ShiftBR),
    .UpdateBR    (UpdateBR),
    .ModeControl (ModeControl),
    .SIN         (SIN),
    .DIN         (DIN),
    .DOUT        (DOUT),
    .SOUT        (SOUT),
    .SegOpen     (SegOpen),
    .ChainLength (ChainLength)
  );

  always #5 ClockBR = ~ClockBR;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: per-SIB and per-segment shift/update bits; the scan path is a list rebuilt on demand.
  bit m_sib_sh[N];
  bit m_sib_up[N];
  bit m_seg_sh[N][W];
  bit m_seg_up[N][W];
  bit path_q[$];

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_sib_sh[k] = 0;
      m_sib_up[k] = 0;
      for (int b = 0; b < W; b++) begin
        m_seg_sh[k][b] = 0;
        m_seg_up[k][b] = 0;
      end
    end
  endtask

  task automatic build_path();
    path_q.delete();
    for (int k = 0; k < N; k++) begin
      path_q.push_back(m_sib_sh[k]);
      if (m_sib_up[k])
        for (int b = 0; b < W; b++) path_q.push_back(m_seg_sh[k][b]);
    end
  endtask

  task automatic scatter_path();
    int p = 0;
    for (int k = 0; k < N; k++) begin
      m_sib_sh[k] = path_q[p];
      p++;
      if (m_sib_up[k])
        for (int b = 0; b < W; b++) begin
          m_seg_sh[k][b] = path_q[p];
          p++;
        end
    end
  endtask

  task automatic model_edge();
    bit sib_o[N];
    bit seg_o[N][W];
    bit open_o[N];
    sib_o  = m_sib_sh;
    seg_o  = m_seg_sh;
    open_o = m_sib_up;
    if (CaptureBR) begin
      for (int k = 0; k < N; k++) begin
        m_sib_sh[k] = m_sib_up[k];
        if (m_sib_up[k])
          for (int b = 0; b < W; b++) m_seg_sh[k][b] = DIN[k*W+b];
      end
    end else if (ShiftBR) begin
      build_path();
      path_q.push_front(SIN);
      void'(path_q.pop_back());
      scatter_path();
    end
    if (UpdateBR) begin
      for (int k = 0; k < N; k++) begin
        m_sib_up[k] = sib_o[k];
        if (open_o[k])
          for (int b = 0; b < W; b++) m_seg_up[k][b] = seg_o[k][b];
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0]   eo;
    logic [N*W-1:0] ed;
    int             len;
    bit             eso;
    build_path();
    eso = path_q[path_q.size()-1];
    for (int k = 0; k < N; k++) begin
      eo[k] = m_sib_up[k];
      for (int b = 0; b < W; b++) ed[k*W+b] = m_seg_up[k][b];
    end
    len = N + W * $countones(eo);
    chk({tag, ":segopen"}, SegOpen, eo);
    chk({tag, ":len"}, ChainLength, len);
    chk({tag, ":sout"}, SOUT, eso);
    chk({tag, ":dout"}, DOUT, ModeControl ? ed : DIN);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge ClockBR);
    #1;
    check_model(tag);
  endtask

  task automatic pulse_reset();
    #2 Rst = 1'b1;
    #2 Rst = 1'b0;
    model_reset();
  endtask

  bit exp_seq[6];

  initial begin
    Rst = 1'b1; CaptureBR = 0; ShiftBR = 0; UpdateBR = 0; ModeControl = 1; SIN = 0;
    DIN = 8'h3C;
    model_reset();
    repeat (2) @(posedge ClockBR);
    #1 Rst = 1'b0;

    chk("rst_len", ChainLength, 2);
    chk("rst_sout", SOUT, 0);
    chk("rst_open", SegOpen, 0);
    chk("rst_dout_test", DOUT, 0);
    ModeControl = 0;
    #1 chk("rst_dout_func", DOUT, 8'h3C);
    ModeControl = 1;

    // Shift 1,1,0 through the two closed SIBs.
    ShiftBR = 1;
    SIN = 1; cycle("sh1");
    SIN = 1; cycle("sh2");
    chk("sh2_sout", SOUT, 1);
    SIN = 0; cycle("sh3");
    chk("sh3_sout", SOUT, 1);
    chk("sh3_len", ChainLength, 2);

    // Open seg0 only.
    SIN = 0; cycle("sh4");
    SIN = 1; cycle("sh5");
    ShiftBR = 0; UpdateBR = 1; cycle("upd1");
    UpdateBR = 0;
    chk("upd1_open", SegOpen, 2'b01);
    chk("upd1_len", ChainLength, 6);

    // Capture A5 and unload.
    DIN = 8'hA5;
    CaptureBR = 1; cycle("cap1");
    CaptureBR = 0; ShiftBR = 1;
    exp_seq = '{0, 0, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cap1_out%0d", i), SOUT, exp_seq[i]);
      SIN = 0;
      cycle("unload1");
    end

    // Load seg0 = 1100 keeping SIB1=0 and SIB0=1, then update.
    exp_seq = '{0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      SIN = exp_seq[i];
      cycle("load2");
    end
    ShiftBR = 0; UpdateBR = 1; cycle("upd2");
    UpdateBR = 0;
    chk("upd2_open", SegOpen, 2'b01);
    chk("upd2_dout", DOUT[3:0], 4'hC);
    ModeControl = 0;
    #1 chk("upd2_dout_func", DOUT, DIN);

    // Capture and shift together: only the capture may happen.
    DIN = {4'($urandom_range(0, 15)), 4'b1001};
    CaptureBR = 1; ShiftBR = 1; SIN = 1; cycle("capsh");
    CaptureBR = 0;
    exp_seq = '{0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("capsh_out%0d", i), SOUT, exp_seq[i]);
      SIN = 0;
      cycle("unload3");
    end
    ShiftBR = 0;

    // Random traffic with overlapping enables.
    for (int i = 0; i < 400; i++) begin
      CaptureBR   = ($urandom_range(0, 7) == 0);
      ShiftBR     = ($urandom_range(0, 3) != 0);
      UpdateBR    = ($urandom_range(0, 5) == 0);
      ModeControl = 1'($urandom);
      SIN         = 1'($urandom);
      DIN         = 8'($urandom);
      cycle("rnd");
    end
    CaptureBR = 0; ShiftBR = 0; UpdateBR = 0;

    // Open both segments, then reset in the middle of a shift.
    pulse_reset();
    ModeControl = 1;
    ShiftBR = 1; SIN = 1;
    cycle("open_a");
    cycle("open_b");
    ShiftBR = 0; UpdateBR = 1; cycle("open_upd");
    UpdateBR = 0;
    chk("open_both", SegOpen, 2'b11);
    chk("open_len", ChainLength, 10);
    ShiftBR = 1;
    for (int i = 0; i < 4; i++) begin
      SIN = 1'($urandom);
      cycle("preclr");
    end
    #2 Rst = 1'b1;
    #1;
    chk("arst_open", SegOpen, 0);
    chk("arst_len", ChainLength, 2);
    chk("arst_dout", DOUT, 0);
    chk("arst_sout", SOUT, 0);
    #1 Rst = 1'b0;
    model_reset();
    ShiftBR = 0;
    cycle("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bs_bsr_sib.md
BS_BSR_SIB -- requirements
Module: bs_bsr_sib

Interface
REQ-001 SHALL have parameter SEG_COUNT, default 4, number of boundary-scan segments (1..16).
REQ-002 SHALL have parameter SEG_WIDTH, default 8, cells per segment (1..64).
REQ-003 SHALL have port ClockBR  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CaptureBR  input  1  parallel-load enable for the active scan path.
REQ-006 SHALL have port ShiftBR  input  1  serial shift enable.
REQ-007 SHALL have port UpdateBR  input  1  update-stage load enable.
REQ-008 SHALL have port ModeControl  input  1  1 = test mode (DOUT from update stage), 0 = functional mode.
REQ-009 SHALL have port SIN  input  1  serial scan input.
REQ-010 SHALL have port DIN  input  SEG_COUNT*SEG_WIDTH  functional data in; segment k occupies bits [k*SEG_WIDTH +: SEG_WIDTH].
REQ-011 SHALL have port DOUT  output  SEG_COUNT*SEG_WIDTH  functional or test data out.
REQ-012 SHALL have port SOUT  output  1  serial scan output.
REQ-013 SHALL have port SegOpen  output  SEG_COUNT  update value of each segment-insertion bit (SIB).
REQ-014 SHALL have port ChainLength  output  clog2(SEG_COUNT*(SEG_WIDTH+1)+1)  current scan-path length in cells.

Function
REQ-015 Each segment k SHALL be preceded by one SIB, which has a shift cell and an update cell.
REQ-016 Scan order SHALL be SIN -> SIB0 -> seg0 bit0..bit(W-1), only when SegOpen[0]=1 -> SIB1 -> ... -> SIB(N-1) -> seg(N-1), only if open -> SOUT.
REQ-017 A closed segment SHALL hold its shift and update cells unchanged during capture, shift and update.
REQ-018 SOUT SHALL equal the shift cell at the tail of the current path, combinationally.
REQ-019 ChainLength SHALL equal SEG_COUNT + SEG_WIDTH * popcount(SegOpen), combinationally.
REQ-020 CaptureBR=1 SHALL load the shift cells of open segments from DIN and each SIB shift cell from its SIB update cell, in one cycle.
REQ-021 ShiftBR=1 with CaptureBR=0 SHALL move every path cell one position toward SOUT per cycle; SIN enters SIB0.
REQ-022 CaptureBR and ShiftBR both asserted SHALL be treated as capture only.
REQ-023 UpdateBR=1 SHALL copy the pre-edge shift-cell values into the update cells of all SIBs and of open segments.
REQ-024 UpdateBR asserted together with Capture or Shift SHALL use the pre-edge shift values; both actions take effect on the same edge.
REQ-025 A new SegOpen value SHALL alter the path, SOUT and ChainLength from the cycle after the update edge.
REQ-026 DOUT SHALL be the segment update cells when ModeControl=1 and DIN when ModeControl=0, combinationally, for all segments.
REQ-027 With no enable asserted, all state SHALL hold.

Reset
REQ-028 Rst SHALL asynchronously clear all shift and update cells, including SIBs, to 0 at any time, including mid-shift.
REQ-029 After reset: SegOpen=0, ChainLength=SEG_COUNT, SOUT=0, DOUT=0 when ModeControl=1 and DOUT=DIN when ModeControl=0.

Structure
REQ-030 Package bs_pkg SHALL hold the default SEG_COUNT/SEG_WIDTH constants and a clog2-based length-width function.
REQ-031 One sub-module, bs_cell, SHALL implement a single shift+update cell with a hold/capture/shift mux, and SHALL be used for both segment cells and SIBs.

Verification
REQ-032 Reset, SEG_COUNT=2, SEG_WIDTH=4; shift SIN=1,1,0 -> ChainLength=2; SOUT shows 1 after the 2nd shift edge and 1 after the 3rd.
REQ-033 Shift 0 then 1, then pulse UpdateBR -> SegOpen=2'b01, ChainLength=6 the next cycle.
REQ-034 With seg0 open and DIN=8'hA5, capture, then shift 6 cycles -> SOUT emits SIB1=0, then seg0 bits 3..0=0,1,0,1, then SIB0=1.
REQ-035 With seg0 open, shift in seg0=4'b1100, update, ModeControl=1 -> DOUT[3:0]=4'hC; ModeControl=0 -> DOUT=DIN.
REQ-036 Assert CaptureBR and ShiftBR together -> capture result only, with no shift.
REQ-037 Assert Rst mid-shift with both segments open -> SegOpen=0, ChainLength=2 and DOUT[7:0]=0 (ModeControl=1) immediately, without waiting for a clock edge.
